stage3_mem_stage: RTL and testbench
===================================

Name: stage3_mem_stage

Overview:
Memory stage of the 3-stage pipeline. It consumes the execute-to-mem register and performs load/store accesses on the generic data bus, stalling until the bus completes. It aligns and sign-extends load data and drives the writeback/forwarding outputs: reg_write, rd_m and reg_wdata. It also forwards brj_addr and pc4 to fetch for redirects.

Parameters:
- BUS_W, 32, data bus and register width.
- BYTE_W, 4, byte enables per bus word.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  instruction present in the ex/mem register.
- ex_ren  in  1  load.
- ex_wen  in  1  store.
- ex_size  in  2  access size: 0 byte, 1 half, 2 word.
- ex_unsigned  in  1  zero-extend load.
- ex_addr  in  32  effective address (ALU result).
- ex_store_data  in  32  rs2 value.
- ex_reg_write  in  1  instruction writes rd.
- ex_rd  in  5  destination register.
- ex_alu_result  in  32  non-load writeback value.
- ex_brj_addr  in  32  resolved branch/jump target.
- ex_pc4  in  32  pc+4.
- flush  in  1  kill current instruction (trap or redirect from a later point).
- dmem_ren  out  1  bus read request.
- dmem_wen  out  1  bus write request.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_byte_en  out  4  lane mask.
- dmem_busy  in  1  bus has not yet completed.
- dmem_rdata  in  32  read data, valid when busy is low.
- mem_stall  out  1  freeze fetch/execute and the ex/mem register.
- misaligned  out  1  address misaligned for the size (one cycle).
- reg_write  out  1  registered writeback enable.
- rd_m  out  5  registered destination register.
- reg_wdata  out  32  registered writeback data.
- brj_addr  out  32  pass-through of ex_brj_addr.
- pc4  out  32  pass-through of ex_pc4.

Behaviour:
- Access condition: req = ex_valid & (ex_ren | ex_wen) & ~misaligned.
- misaligned is combinational:
  - half with addr[0] set;
  - word with addr[1:0] nonzero.
  - A misaligned access issues no bus request and no writeback.
- FSM states: IDLE, ACCESS, DRAIN. All state and registered outputs reset to IDLE/0 asynchronously.
- IDLE:
  - If req & ~flush, assert ren or wen this cycle.
  - If dmem_busy is low the same cycle, complete in 0 wait cycles and stay in IDLE.
  - Otherwise go to ACCESS.
- ACCESS:
  - Hold ren/wen, addr, wdata and byte_en stable.
  - On the first cycle with busy low, complete and return to IDLE.
  - If flush arrives, go to DRAIN. The bus transaction is never aborted.
- DRAIN:
  - Hold the request until busy is low, then return to IDLE.
  - Discard the result: no register write, and a flushed store still completes on the bus.
- mem_stall = req & dmem_busy in IDLE/ACCESS; mem_stall = 1 throughout DRAIN.
- Byte enables:
  - byte: 1 << addr[1:0];
  - half: 0011 or 1100 by addr[1];
  - word: 1111.
- Store data replicated across lanes: byte ×4, half ×2.
- Load extraction: select the lane by addr[1:0], then sign- or zero-extend per ex_unsigned.
- MEM/WB register, updated every cycle when mem_stall is low:
  - reg_write = ex_valid & ex_reg_write & ~flush & ~misaligned;
  - rd_m = ex_rd;
  - reg_wdata = load data if ex_ren, else ex_alu_result.
- While mem_stall is high, the MEM/WB register inserts a bubble (reg_write = 0).
- rd_m and reg_write are zero when there is no valid instruction.
- Reset mid-access returns to IDLE immediately and drops all requests.

Decomposition:
- Shared package (stage3_types_pkg): mem_size_t enum (BYTE, HALF, WORD), mem_state_t enum (IDLE, ACCESS, DRAIN).
- One sub-module: stage3_mem_align. It is purely combinational and produces byte_en, store replication, load extraction/extension and misaligned.

Test Plan:
- lw at 0x100, busy low immediately, rdata 0xDEADBEEF → reg_wdata 0xDEADBEEF, rd_m = rd, mem_stall never high.
- lb unsigned=0 at 0x103, busy held 3 cycles, rdata 0x80FF0000 → mem_stall high 3 cycles, request stable, reg_wdata 0xFFFFFF80.
- sh data 0x1234ABCD at 0x102 → byte_en 1100, wdata 0xABCDABCD, reg_write 0.
- lw at 0x101 → misaligned = 1, no ren, reg_write 0, no stall.
- lw with busy high 4 cycles, flush in cycle 2 → DRAIN, ren held until busy low, reg_write stays 0, return to IDLE.
- nRST asserted while in ACCESS → ren/wen/mem_stall/reg_write 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/stage3_types_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stage3_types_pkg                                          |
// | Purpose  : Shared types for the memory stage of the 3-stage pipeline:|
// |            access-size encoding and the bus-access FSM states.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package stage3_types_pkg;

  // Access size as carried on ex_size.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  // Data-bus access sequencing.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/stage3_mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stage3_mem_align                                          |
// | Purpose  : Combinational lane logic for loads and stores.            |
// |   size        in   access size (byte/half/word)                      |
// |   offset      in   byte offset within the bus word                   |
// |   is_unsigned in   zero-extend loads instead of sign-extending       |
// |   store_data  in   register value to store                           |
// |   rdata       in   raw bus read data                                 |
// |   byte_en     out  lane mask for the access                          |
// |   wdata       out  store data replicated across lanes                |
// |   load_data   out  selected lane, extended to full width             |
// |   misaligned  out  offset not a multiple of the access size          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stage3_mem_align
  import stage3_types_pkg::*;
#(
  parameter int BUS_W  = 32,
  parameter int BYTE_W = 4
) (
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [BUS_W-1:0]  store_data,
  input  logic [BUS_W-1:0]  rdata,
  output logic [BYTE_W-1:0] byte_en,
  output logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  load_data,
  output logic              misaligned
);

  // Shift the addressed lane down to bit 0 so every size extracts from
  // the bottom of the word.
  logic [BUS_W-1:0] w_lane;
  assign w_lane = rdata >> {offset, 3'b000};

  always_comb begin
    // Word access (and the unused size encoding) is the default.
    byte_en    = '1;
    wdata      = store_data;
    load_data  = w_lane;
    misaligned = |offset;
    case (mem_size_t'(size))
      BYTE: begin
        byte_en    = BYTE_W'(1) << offset;
        wdata      = {BYTE_W{store_data[7:0]}};
        load_data  = is_unsigned ? {{(BUS_W-8){1'b0}}, w_lane[7:0]}
                                 : {{(BUS_W-8){w_lane[7]}}, w_lane[7:0]};
        misaligned = 1'b0;
      end
      HALF: begin
        byte_en    = BYTE_W'(2'b11) << {offset[1], 1'b0};
        wdata      = {(BYTE_W/2){store_data[15:0]}};
        load_data  = is_unsigned ? {{(BUS_W-16){1'b0}}, w_lane[15:0]}
                                 : {{(BUS_W-16){w_lane[15]}}, w_lane[15:0]};
        misaligned = offset[0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stage3_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : stage3_mem_stage                                          |
// | Purpose  : Memory stage: issues loads/stores on the data bus, stalls |
// |            until completion, aligns load data and registers the      |
// |            writeback (MEM/WB) values.                                |
// |   CLK, nRST            clock, async active-low reset                 |
// |   ex_*                 ex/mem pipeline register contents             |
// |   flush                kill the current instruction                  |
// |   dmem_*               generic data bus (req/busy handshake)         |
// |   mem_stall            freeze upstream stages and ex/mem register    |
// |   misaligned           access misaligned for its size                |
// |   reg_write/rd_m/reg_wdata  MEM/WB writeback + forwarding            |
// |   brj_addr, pc4        pass-through to fetch for redirects           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module stage3_mem_stage
  import stage3_types_pkg::*;
#(
  parameter int BUS_W  = 32,
  parameter int BYTE_W = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_ren,
  input  logic              ex_wen,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [BUS_W-1:0]  ex_addr,
  input  logic [BUS_W-1:0]  ex_store_data,
  input  logic              ex_reg_write,
  input  logic [4:0]        ex_rd,
  input  logic [BUS_W-1:0]  ex_alu_result,
  input  logic [BUS_W-1:0]  ex_brj_addr,
  input  logic [BUS_W-1:0]  ex_pc4,
  input  logic              flush,
  output logic              dmem_ren,
  output logic              dmem_wen,
  output logic [BUS_W-1:0]  dmem_addr,
  output logic [BUS_W-1:0]  dmem_wdata,
  output logic [BYTE_W-1:0] dmem_byte_en,
  input  logic              dmem_busy,
  input  logic [BUS_W-1:0]  dmem_rdata,
  output logic              mem_stall,
  output logic              misaligned,
  output logic              reg_write,
  output logic [4:0]        rd_m,
  output logic [BUS_W-1:0]  reg_wdata,
  output logic [BUS_W-1:0]  brj_addr,
  output logic [BUS_W-1:0]  pc4
);

  logic              w_is_mem;
  logic              w_align_mis;
  logic              w_req;
  logic              w_issue;
  logic [BYTE_W-1:0] w_byte_en;
  logic [BUS_W-1:0]  w_wdata;
  logic [BUS_W-1:0]  w_load_data;
  logic [BUS_W-1:0]  w_addr_word;

  mem_state_t        r_state;
  mem_state_t        w_state_next;

  // Request captured at issue; replayed in ACCESS/DRAIN so the bus sees a
  // stable request even if the ex/mem register is flushed underneath it.
  logic              r_ren;
  logic              r_wen;
  logic [BUS_W-1:0]  r_addr;
  logic [BUS_W-1:0]  r_wdata;
  logic [BYTE_W-1:0] r_byte_en;

  stage3_mem_align #(
    .BUS_W  (BUS_W),
    .BYTE_W (BYTE_W)
  ) u_align (
    .size        (ex_size),
    .offset      (ex_addr[1:0]),
    .is_unsigned (ex_unsigned),
    .store_data  (ex_store_data),
    .rdata       (dmem_rdata),
    .byte_en     (w_byte_en),
    .wdata       (w_wdata),
    .load_data   (w_load_data),
    .misaligned  (w_align_mis)
  );

  // Only real memory instructions can be misaligned; an ALU op whose
  // result happens to be odd must not be killed.
  assign w_is_mem    = ex_valid & (ex_ren | ex_wen);
  assign misaligned  = w_is_mem & w_align_mis;
  assign w_req       = w_is_mem & ~w_align_mis;
  assign w_addr_word = {ex_addr[BUS_W-1:2], 2'b00};

  assign brj_addr = ex_brj_addr;
  assign pc4      = ex_pc4;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    dmem_ren     = 1'b0;
    dmem_wen     = 1'b0;
    dmem_addr    = w_addr_word;
    dmem_wdata   = w_wdata;
    dmem_byte_en = w_byte_en;
    mem_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req & ~flush) begin
          w_issue  = 1'b1;
          dmem_ren = ex_ren;
          dmem_wen = ex_wen;
          // A flushed instruction never reaches the bus, so it must not
          // wait on a busy flag that belongs to nobody.
          mem_stall = dmem_busy;
          if (dmem_busy) begin
            w_state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        dmem_ren     = r_ren;
        dmem_wen     = r_wen;
        dmem_addr    = r_addr;
        dmem_wdata   = r_wdata;
        dmem_byte_en = r_byte_en;
        mem_stall    = w_req & dmem_busy;
        if (!dmem_busy) begin
          w_state_next = IDLE;
        end else if (flush) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The bus cannot abort, so ride the transaction out and drop the
        // result; stall the whole time so nothing new is issued.
        dmem_ren     = r_ren;
        dmem_wen     = r_wen;
        dmem_addr    = r_addr;
        dmem_wdata   = r_wdata;
        dmem_byte_en = r_byte_en;
        mem_stall    = 1'b1;
        if (!dmem_busy) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    // Requests drop the moment reset is asserted, not at the next edge.
    if (!nRST) begin
      w_issue   = 1'b0;
      dmem_ren  = 1'b0;
      dmem_wen  = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_ren     <= 1'b0;
      r_wen     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_byte_en <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue) begin
        r_ren     <= ex_ren;
        r_wen     <= ex_wen;
        r_addr    <= w_addr_word;
        r_wdata   <= w_wdata;
        r_byte_en <= w_byte_en;
      end
    end
  end

  // MEM/WB register: a stalled cycle becomes a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      reg_write <= 1'b0;
      rd_m      <= '0;
      reg_wdata <= '0;
    end else if (mem_stall) begin
      reg_write <= 1'b0;
      rd_m      <= '0;
    end else begin
      reg_write <= ex_valid & ex_reg_write & ~flush & ~misaligned;
      rd_m      <= ex_valid ? ex_rd : 5'd0;
      reg_wdata <= ex_ren ? w_load_data : ex_alu_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage3_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_stage3_mem_stage                                       |
// | Purpose  : Self-checking bench for stage3_mem_stage: directed vector |
// |            table, random transactions against a byte-level model,   |
// |            and hand sequences for wait states, flush and reset.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_stage3_mem_stage;

  logic        CLK;
  logic        nRST;
  logic        ex_valid, ex_ren, ex_wen, ex_unsigned, ex_reg_write, flush;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_store_data, ex_alu_result, ex_brj_addr, ex_pc4;
  logic [4:0]  ex_rd;
  logic        dmem_ren, dmem_wen, dmem_busy;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_en;
  logic        mem_stall, misaligned, reg_write;
  logic [4:0]  rd_m;
  logic [31:0] reg_wdata, brj_addr, pc4;

  stage3_mem_stage #(.BUS_W(32), .BYTE_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_ren(ex_ren), .ex_wen(ex_wen), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
    .ex_brj_addr(ex_brj_addr), .ex_pc4(ex_pc4), .flush(flush),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .dmem_busy(dmem_busy),
    .dmem_rdata(dmem_rdata), .mem_stall(mem_stall), .misaligned(misaligned),
    .reg_write(reg_write), .rd_m(rd_m), .reg_wdata(reg_wdata),
    .brj_addr(brj_addr), .pc4(pc4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid, ren, wen;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, sdata;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu, rdata;
    logic        fl;
  } stim_t;

  typedef struct {
    logic        ren, wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        mis, rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        chk_wd;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
  endtask

  task automatic drive(input stim_t s);
    ex_valid      = s.valid;
    ex_ren        = s.ren;
    ex_wen        = s.wen;
    ex_size       = s.size;
    ex_unsigned   = s.uns;
    ex_addr       = s.addr;
    ex_store_data = s.sdata;
    ex_rd         = s.rd;
    ex_reg_write  = s.rw;
    ex_alu_result = s.alu;
    flush         = s.fl;
  endtask

  // Reference model: works in bytes and powers of two, straight from the
  // access rules (size in bytes, lane offset, replication, extension).
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    int          n, off;
    logic [63:0] v;
    logic        mem;
    n   = (s.size == 2'd0) ? 1 : (s.size == 2'd1) ? 2 : 4;
    off = int'(s.addr[1:0]);
    mem = s.valid && (s.ren || s.wen);
    e.mis = mem && ((off % n) != 0);
    e.ren = mem && !e.mis && !s.fl && s.ren;
    e.wen = mem && !e.mis && !s.fl && s.wen;
    e.be  = 4'(((1 << n) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = 8'(s.sdata >> (8 * (i % n)));
    v = (64'(s.rdata) >> (8 * off)) & ((64'd1 << (8 * n)) - 64'd1);
    if (!s.uns && v[8*n-1]) v = v - (64'd1 << (8 * n));
    e.wd     = s.ren ? v[31:0] : s.alu;
    e.rw     = s.valid && s.rw && !s.fl && !e.mis;
    e.rd     = s.valid ? s.rd : 5'd0;
    e.chk_wd = e.rw;
    return e;
  endfunction

  // Called on a negedge. Busy is held high for 'lat' cycles after the
  // request appears; the final cycle returns s.rdata with busy low.
  task automatic run_txn(input string tag, input stim_t s, input exp_t e, input int lat);
    logic [69:0] snap, cur;
    logic [31:0] brj, pc;
    int stalls, unstable, bubbles;
    stalls = 0; unstable = 0; bubbles = 0; snap = '0;
    drive(s);
    brj = $urandom; pc = $urandom;
    ex_brj_addr = brj; ex_pc4 = pc;
    for (int k = 0; k <= lat; k++) begin
      dmem_busy  = (k < lat);
      dmem_rdata = (k < lat) ? $urandom : s.rdata;
      #1;
      cur = {dmem_ren, dmem_wen, dmem_addr, dmem_byte_en, dmem_wdata};
      if (k == 0) begin
        snap = cur;
        chk($sformatf("%s ren", tag), 32'(dmem_ren), 32'(e.ren));
        chk($sformatf("%s wen", tag), 32'(dmem_wen), 32'(e.wen));
        chk($sformatf("%s misaligned", tag), 32'(misaligned), 32'(e.mis));
        if (e.ren || e.wen) begin
          chk($sformatf("%s addr", tag), dmem_addr, {s.addr[31:2], 2'b00});
          chk($sformatf("%s byte_en", tag), 32'(dmem_byte_en), 32'(e.be));
          chk($sformatf("%s wdata", tag), dmem_wdata, e.wdata);
        end
        chk($sformatf("%s brj_addr", tag), brj_addr, brj);
        chk($sformatf("%s pc4", tag), pc4, pc);
      end else if (cur !== snap) begin
        unstable++;
      end
      if (mem_stall) stalls++;
      @(posedge CLK); #1;
      if (k < lat && reg_write !== 1'b0) bubbles++;
      @(negedge CLK);
    end
    chk($sformatf("%s stall_cycles", tag), stalls, lat);
    if (lat > 0) begin
      chk($sformatf("%s req_unstable", tag), unstable, 0);
      chk($sformatf("%s bubble_violations", tag), bubbles, 0);
    end
    chk($sformatf("%s reg_write", tag), 32'(reg_write), 32'(e.rw));
    chk($sformatf("%s rd_m", tag), 32'(rd_m), 32'(e.rd));
    if (e.chk_wd) chk($sformatf("%s reg_wdata", tag), reg_wdata, e.wd);
    dmem_busy = 1'b0;
    flush     = 1'b0;
  endtask

  vec_t  tbl [14];
  stim_t s;
  exp_t  e;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // {valid,ren,wen,size,uns,addr,sdata,rd,rw,alu,rdata,flush} , {ren,wen,be,wdata,mis,rw,rd,wd,chk_wd}
    tbl[0]  = '{'{1'b1,1'b1,1'b0,2'd2,1'b0,32'h100,32'h11223344,5'd5,1'b1,32'h0,32'hDEADBEEF,1'b0}, '{1'b1,1'b0,4'hF,32'h11223344,1'b0,1'b1,5'd5,32'hDEADBEEF,1'b1}};
    tbl[1]  = '{'{1'b1,1'b1,1'b0,2'd0,1'b1,32'h101,32'hAABBCCDD,5'd7,1'b1,32'h0,32'h12345678,1'b0}, '{1'b1,1'b0,4'h2,32'hDDDDDDDD,1'b0,1'b1,5'd7,32'h00000056,1'b1}};
    tbl[2]  = '{'{1'b1,1'b1,1'b0,2'd1,1'b0,32'h102,32'h1234ABCD,5'd3,1'b1,32'h0,32'h80011234,1'b0}, '{1'b1,1'b0,4'hC,32'hABCDABCD,1'b0,1'b1,5'd3,32'hFFFF8001,1'b1}};
    tbl[3]  = '{'{1'b1,1'b1,1'b0,2'd1,1'b1,32'h102,32'h1234ABCD,5'd4,1'b1,32'h0,32'h80011234,1'b0}, '{1'b1,1'b0,4'hC,32'hABCDABCD,1'b0,1'b1,5'd4,32'h00008001,1'b1}};
    tbl[4]  = '{'{1'b1,1'b0,1'b1,2'd1,1'b0,32'h102,32'h1234ABCD,5'd0,1'b0,32'h55,32'h0,1'b0},      '{1'b0,1'b1,4'hC,32'hABCDABCD,1'b0,1'b0,5'd0,32'h00000055,1'b1}};
    tbl[5]  = '{'{1'b1,1'b0,1'b1,2'd0,1'b0,32'h103,32'h000000A5,5'd2,1'b0,32'h77,32'h0,1'b0},      '{1'b0,1'b1,4'h8,32'hA5A5A5A5,1'b0,1'b0,5'd2,32'h00000077,1'b1}};
    tbl[6]  = '{'{1'b1,1'b0,1'b1,2'd2,1'b0,32'h200,32'hCAFEF00D,5'd0,1'b0,32'h99,32'h0,1'b0},      '{1'b0,1'b1,4'hF,32'hCAFEF00D,1'b0,1'b0,5'd0,32'h00000099,1'b1}};
    tbl[7]  = '{'{1'b1,1'b1,1'b0,2'd2,1'b0,32'h101,32'h0,5'd9,1'b1,32'h0,32'h12345678,1'b0},       '{1'b0,1'b0,4'h0,32'h0,1'b1,1'b0,5'd9,32'h0,1'b0}};
    tbl[8]  = '{'{1'b1,1'b1,1'b0,2'd1,1'b1,32'h103,32'h0,5'd10,1'b1,32'h0,32'h0,1'b0},             '{1'b0,1'b0,4'h0,32'h0,1'b1,1'b0,5'd10,32'h0,1'b0}};
    tbl[9]  = '{'{1'b1,1'b0,1'b0,2'd2,1'b0,32'h12345677,32'h0,5'd12,1'b1,32'h12345678,32'h0,1'b0},'{1'b0,1'b0,4'h0,32'h0,1'b0,1'b1,5'd12,32'h12345678,1'b1}};
    tbl[10] = '{'{1'b0,1'b1,1'b0,2'd2,1'b0,32'h100,32'h0,5'd6,1'b1,32'hAB,32'hFFFFFFFF,1'b0},      '{1'b0,1'b0,4'h0,32'h0,1'b0,1'b0,5'd0,32'hFFFFFFFF,1'b1}};
    tbl[11] = '{'{1'b1,1'b1,1'b0,2'd0,1'b0,32'h103,32'h0,5'd8,1'b1,32'h0,32'h80FF0000,1'b0},       '{1'b1,1'b0,4'h8,32'h0,1'b0,1'b1,5'd8,32'hFFFFFF80,1'b1}};
    tbl[12] = '{'{1'b1,1'b1,1'b0,2'd2,1'b0,32'h100,32'h0,5'd4,1'b1,32'h0,32'h1,1'b1},              '{1'b0,1'b0,4'h0,32'h0,1'b0,1'b0,5'd4,32'h0,1'b0}};
    tbl[13] = '{'{1'b1,1'b1,1'b0,2'd0,1'b0,32'h100,32'h5A,5'd11,1'b1,32'h0,32'h0000007F,1'b0},     '{1'b1,1'b0,4'h1,32'h5A5A5A5A,1'b0,1'b1,5'd11,32'h0000007F,1'b1}};

    // Reset state.
    nRST = 1'b0; dmem_busy = 1'b0; dmem_rdata = '0;
    ex_brj_addr = '0; ex_pc4 = '0;
    drive('{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,5'd0,1'b0,32'h0,32'h0,1'b0});
    #1;
    chk("reset reg_write", 32'(reg_write), 32'd0);
    chk("reset rd_m", 32'(rd_m), 32'd0);
    chk("reset reg_wdata", reg_wdata, 32'd0);
    chk("reset dmem_ren", 32'(dmem_ren), 32'd0);
    chk("reset mem_stall", 32'(mem_stall), 32'd0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Directed vectors, zero wait states.
    for (int i = 0; i < 14; i++) run_txn($sformatf("vec%0d", i), tbl[i].s, tbl[i].e, 0);

    // lb at 0x103 with three busy cycles.
    run_txn("lb_wait3", tbl[11].s, tbl[11].e, 3);

    // Flush during a long load: drain until the bus finishes, no writeback.
    begin
      int ren_drops, stall_lo, rw_seen;
      ren_drops = 0; stall_lo = 0; rw_seen = 0;
      drive('{1'b1,1'b1,1'b0,2'd2,1'b0,32'h180,32'h0,5'd13,1'b1,32'h0,32'h0,1'b0});
      for (int k = 0; k <= 5; k++) begin
        dmem_busy  = (k < 4);
        dmem_rdata = 32'h13579BDF;
        flush      = (k == 1);
        if (k >= 2) ex_valid = 1'b0;
        #1;
        if (k <= 4) begin
          if (dmem_ren !== 1'b1 || dmem_addr !== 32'h180) ren_drops++;
          if (mem_stall !== 1'b1) stall_lo++;
        end else begin
          chk("flush idle ren", 32'(dmem_ren), 32'd0);
          chk("flush idle stall", 32'(mem_stall), 32'd0);
        end
        @(posedge CLK); #1;
        if (reg_write !== 1'b0) rw_seen++;
        @(negedge CLK);
      end
      chk("flush ren_drops", ren_drops, 0);
      chk("flush stall_low_cycles", stall_lo, 0);
      chk("flush reg_write_seen", rw_seen, 0);
      flush = 1'b0;
    end

    // Asynchronous reset of the MEM/WB register.
    drive('{1'b1,1'b0,1'b0,2'd2,1'b0,32'h0,32'h0,5'd14,1'b1,32'h2468,32'h0,1'b0});
    dmem_busy = 1'b0;
    @(posedge CLK); #1;
    chk("rst_pre reg_write", 32'(reg_write), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_async reg_write", 32'(reg_write), 32'd0);
    chk("rst_async rd_m", 32'(rd_m), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset while in ACCESS.
    drive('{1'b1,1'b1,1'b0,2'd2,1'b0,32'h140,32'h0,5'd15,1'b1,32'h0,32'h0,1'b0});
    dmem_busy = 1'b1;
    #1;
    chk("rst_acc pre ren", 32'(dmem_ren), 32'd1);
    chk("rst_acc pre stall", 32'(mem_stall), 32'd1);
    @(posedge CLK); #1;
    #2 nRST = 1'b0;
    #1;
    chk("rst_acc ren", 32'(dmem_ren), 32'd0);
    chk("rst_acc wen", 32'(dmem_wen), 32'd0);
    chk("rst_acc stall", 32'(mem_stall), 32'd0);
    chk("rst_acc reg_write", 32'(reg_write), 32'd0);
    @(negedge CLK);
    ex_valid = 1'b0; dmem_busy = 1'b0; nRST = 1'b1;
    @(negedge CLK);
    run_txn("post_rst", tbl[0].s, tbl[0].e, 0);

    // Random transactions against the model.
    for (int i = 0; i < 300; i++) begin
      int kind, lat;
      kind     = int'($urandom_range(0, 2));
      s.valid  = ($urandom_range(0, 7) != 0);
      s.ren    = (kind == 0);
      s.wen    = (kind == 1);
      s.size   = 2'($urandom_range(0, 2));
      s.uns    = 1'($urandom_range(0, 1));
      s.addr   = $urandom;
      s.sdata  = $urandom;
      s.rd     = 5'($urandom_range(0, 31));
      s.rw     = (kind == 0) ? 1'b1 : (kind == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      s.alu    = $urandom;
      s.rdata  = $urandom;
      s.fl     = ($urandom_range(0, 15) == 0);
      e        = model(s);
      lat      = (e.ren || e.wen) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3))) : 0;
      run_txn($sformatf("rnd%0d", i), s, e, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
